// File: rtl/spi_ram_master.sv
// spi_ram_master: turns single host memory commands into SPI frames for the
// SPI slave + 256x8 RAM subsystem. A frame is a select bit (cmd_op[1]) followed
// by the 10-bit word {cmd_op, cmd_data}, MSB first. Read-data frames then wait
// RD_WAIT cycles for the slave/RAM turnaround and capture 8 MISO bits.
// Every output is registered from the next-state value, so outputs line up
// with the state they belong to.
module spi_ram_master #(
   parameter int RD_WAIT  = 2,   // legal 1..15
   parameter int IDLE_GAP = 1    // legal 1..15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       MOSI,
   input  logic       MISO,
   output logic       ss_n
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEL   = 3'd1,
      S_SHIFT = 3'd2,
      S_WAIT  = 3'd3,
      S_CAPT  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   // Down-counter reload values: a counter loaded with N-1 spans N cycles.
   localparam logic [3:0] RD_LOAD    = 4'(RD_WAIT - 1);
   localparam logic [3:0] GAP_LOAD   = 4'(IDLE_GAP - 1);
   localparam logic [3:0] SHIFT_LOAD = 4'd9;
   localparam logic [3:0] CAPT_LOAD  = 4'd7;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [9:0]  frame_reg, frame_next;
   logic [7:0]  cap_reg, cap_next;
   logic        accept;

   logic        ss_n_reg, ss_n_next;
   logic        mosi_reg, mosi_next;
   logic        cmd_ready_reg, cmd_ready_next;
   logic        busy_reg, busy_next;
   logic        rsp_valid_reg, rsp_valid_next;
   logic [7:0]  rsp_data_reg, rsp_data_next;

   assign accept    = cmd_valid && (state_reg == S_IDLE);

   assign ss_n      = ss_n_reg;
   assign MOSI      = mosi_reg;
   assign cmd_ready = cmd_ready_reg;
   assign busy      = busy_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;

   // State, datapath and output registers; reset releases the bus at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= 4'd0;
         frame_reg     <= 10'd0;
         cap_reg       <= 8'd0;
         ss_n_reg      <= 1'b1;
         mosi_reg      <= 1'b0;
         cmd_ready_reg <= 1'b1;
         busy_reg      <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= 8'h00;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         frame_reg     <= frame_next;
         cap_reg       <= cap_next;
         ss_n_reg      <= ss_n_next;
         mosi_reg      <= mosi_next;
         cmd_ready_reg <= cmd_ready_next;
         busy_reg      <= busy_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_data_reg  <= rsp_data_next;
      end
   end

   // Next-state, phase counter, frame latch and MISO capture shifting.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      frame_next = frame_reg;
      cap_next   = cap_reg;
      unique case (state_reg)
         S_IDLE: begin
            if (accept) begin
               frame_next = {cmd_op, cmd_data};
               state_next = S_SEL;
            end
         end
         S_SEL: begin
            state_next = S_SHIFT;
            cnt_next   = SHIFT_LOAD;
         end
         S_SHIFT: begin
            if (cnt_reg == 4'd0) begin
               if (frame_reg[9:8] == 2'b11) begin
                  state_next = S_WAIT;
                  cnt_next   = RD_LOAD;
               end else begin
                  state_next = S_GAP;
                  cnt_next   = GAP_LOAD;
               end
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         S_WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = S_CAPT;
               cnt_next   = CAPT_LOAD;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         S_CAPT: begin
            cap_next = {cap_reg[6:0], MISO};
            if (cnt_reg == 4'd0) begin
               state_next = S_GAP;
               cnt_next   = GAP_LOAD;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         S_GAP: begin
            if (cnt_reg == 4'd0) begin
               state_next = S_IDLE;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the next state.
   always_comb begin
      ss_n_next      = 1'b1;
      mosi_next      = 1'b0;
      cmd_ready_next = 1'b0;
      busy_next      = 1'b1;
      rsp_valid_next = 1'b0;
      rsp_data_next  = rsp_data_reg;
      unique case (state_next)
         S_IDLE: begin
            cmd_ready_next = 1'b1;
            busy_next      = 1'b0;
         end
         S_SEL: begin
            ss_n_next = 1'b0;
            mosi_next = frame_next[9];
         end
         S_SHIFT: begin
            ss_n_next = 1'b0;
            mosi_next = frame_next[cnt_next];
         end
         S_WAIT, S_CAPT: begin
            ss_n_next = 1'b0;
         end
         default: begin
            ss_n_next = 1'b1;
         end
      endcase
      // The completed byte is published on the cycle the frame closes.
      if (state_reg == S_CAPT && state_next == S_GAP) begin
         rsp_valid_next = 1'b1;
         rsp_data_next  = cap_next;
      end
   end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: a behavioural SPI slave + 256x8 RAM answers the
// frames, expected MOSI frames and read bytes go through scoreboard queues,
// and each scenario task checks its own traces. Cycle N is the clock period
// ending at edge N, where edge 0 is the accept edge; it is sampled at its negedge.
module tb_spi_ram_master;
   localparam int RD_WAIT  = 2;
   localparam int IDLE_GAP = 1;
   localparam int WR_CYC   = 13;
   localparam int RD_CYC   = 22 + RD_WAIT;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       busy;
   logic       MOSI;
   logic       MISO;
   logic       ss_n;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [10:0] exp_frame_q[$];
   logic [7:0]  exp_rsp_q[$];

   always #5 clk = ~clk;

   spi_ram_master #(.RD_WAIT(RD_WAIT), .IDLE_GAP(IDLE_GAP)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .busy(busy), .MOSI(MOSI), .MISO(MISO), .ss_n(ss_n)
   );

   // Behavioural slave + RAM: 11 bits in, then read data back after RD_WAIT.
   logic [7:0]  slave_mem [256];
   logic [7:0]  s_addr  = 8'h00;
   logic [10:0] s_shift = 11'd0;
   int          s_cnt   = 0;

   always @(posedge clk) begin
      if (!ss_n) begin
         if (s_cnt < 11) s_shift <= {s_shift[9:0], MOSI};
         s_cnt <= s_cnt + 1;
      end else begin
         if (s_cnt >= 11) begin
            case (s_shift[9:8])
               2'b00:   s_addr <= s_shift[7:0];
               2'b01:   slave_mem[s_addr] <= s_shift[7:0];
               2'b10:   s_addr <= s_shift[7:0];
               default: ;
            endcase
         end
         s_cnt <= 0;
      end
   end

   assign MISO = (!ss_n && s_shift[9:8] == 2'b11 && s_cnt >= 11 + RD_WAIT && s_cnt <= 18 + RD_WAIT)
                 ? slave_mem[s_addr][3'(18 + RD_WAIT - s_cnt)] : 1'b0;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [10:0] frame_bits(input logic [31:0] t);
      logic [10:0] f;
      for (int i = 1; i <= 11; i++) f[11-i] = t[i];
      return f;
   endfunction

   // Trace with bit i set for cycles i >= from (bit 0 unused).
   function automatic logic [31:0] high_from(input int from, input int ncyc);
      logic [31:0] v = '0;
      for (int i = 1; i <= ncyc; i++) v[i] = (i >= from);
      return v;
   endfunction

   task automatic accept_cmd(input logic [1:0] op, input logic [7:0] data,
                             input bit hold, output int wc);
      cmd_op    = op;
      cmd_data  = data;
      cmd_valid = 1'b1;
      wc        = -1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) begin
            wc = i;
            break;
         end
      end
      if (wc < 0) begin
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic run_frame(input logic [1:0] op, input logic [7:0] data, input bit hold,
                            input int ncyc, input logic [7:0] exp_rsp, output int wc,
                            output logic [31:0] ss_t, output logic [31:0] mo_t,
                            output logic [31:0] rv_t, output logic [31:0] rdy_t,
                            output logic [7:0] rsp_seen);
      ss_t = '0; mo_t = '0; rv_t = '0; rdy_t = '0; rsp_seen = 8'h00;
      exp_frame_q.push_back({op[1], op, data});
      if (op == 2'b11) exp_rsp_q.push_back(exp_rsp);
      accept_cmd(op, data, hold, wc);
      if (wc < 0) return;
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clk);
         ss_t[i] = ss_n; mo_t[i] = MOSI; rv_t[i] = rsp_valid; rdy_t[i] = cmd_ready;
         if (rsp_valid === 1'b1) rsp_seen = rsp_data;
         if (hold) cmd_data = 8'($urandom);
      end
      if (hold) cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({ss_n, MOSI, cmd_ready, busy, rsp_valid} !== 5'b10100) begin
         tests_failed++;
         $display("FAIL reset_ctrl: {ss_n,MOSI,cmd_ready,busy,rsp_valid} got %b want 10100",
                  {ss_n, MOSI, cmd_ready, busy, rsp_valid});
      end
      tests_run++;
      if (rsp_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_rsp_data: got %h want 00", rsp_data);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b1 || ss_n !== 1'b1) begin
         tests_failed++;
         $display("FAIL post_reset_idle: cmd_ready %b ss_n %b want 1 1", cmd_ready, ss_n);
      end
      $display("[TB] reset: done");
   endtask

   task automatic test_write_addr;
      int wc; logic [31:0] ss_t, mo_t, rv_t, rdy_t; logic [7:0] rd;
      logic [10:0] want;
      logic [10:0] spec_seq = 11'b00010100101;
      run_frame(2'b00, 8'hA5, 1'b0, WR_CYC, 8'h00, wc, ss_t, mo_t, rv_t, rdy_t, rd);
      want = exp_frame_q.pop_front();
      tests_run++;
      if (wc < 0) begin
         tests_failed++;
         $display("FAIL wa_accept: cmd_ready never high within 100 cycles");
      end
      tests_run++;
      if (frame_bits(mo_t) !== want || want !== spec_seq) begin
         tests_failed++;
         $display("FAIL wa_mosi: got %b want %b", frame_bits(mo_t), spec_seq);
      end
      tests_run++;
      if (ss_t[WR_CYC:1] !== high_from(12, WR_CYC)[WR_CYC:1]) begin
         tests_failed++;
         $display("FAIL wa_ss_n: got %b want %b", ss_t[WR_CYC:1], high_from(12, WR_CYC)[WR_CYC:1]);
      end
      tests_run++;
      if (rv_t !== 32'd0 || mo_t[WR_CYC:12] !== 2'b00) begin
         tests_failed++;
         $display("FAIL wa_quiet: rsp_valid trace %b MOSI after frame %b want all 0",
                  rv_t, mo_t[WR_CYC:12]);
      end
      $display("[TB] write addr A5: mosi %b ss_n %b", frame_bits(mo_t), ss_t[WR_CYC:1]);
   endtask

   task automatic test_back_to_back;
      int wc1, wc2; logic [31:0] ss1, mo1, rv1, rdy1, ss2, mo2, rv2, rdy2; logic [7:0] rd;
      logic [10:0] want;
      run_frame(2'b01, 8'h3C, 1'b0, 12, 8'h00, wc1, ss1, mo1, rv1, rdy1, rd);
      run_frame(2'b10, 8'hA5, 1'b0, WR_CYC, 8'h00, wc2, ss2, mo2, rv2, rdy2, rd);
      want = exp_frame_q.pop_front();
      tests_run++;
      if (frame_bits(mo1) !== want) begin
         tests_failed++;
         $display("FAIL b2b_frame1: got %b want %b", frame_bits(mo1), want);
      end
      want = exp_frame_q.pop_front();
      tests_run++;
      if (frame_bits(mo2) !== want) begin
         tests_failed++;
         $display("FAIL b2b_frame2: got %b want %b", frame_bits(mo2), want);
      end
      tests_run++;
      if (rdy1[12:1] !== 12'd0) begin
         tests_failed++;
         $display("FAIL b2b_ready_low: cmd_ready trace %b want all 0", rdy1[12:1]);
      end
      tests_run++;
      if (wc2 != IDLE_GAP) begin
         tests_failed++;
         $display("FAIL b2b_gap: ss_n fell %0d cycles after rising, want %0d", wc2 + 1, IDLE_GAP + 1);
      end
      tests_run++;
      if (ss2[1] !== 1'b0 || mo2[1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_read_select: ss_n %b MOSI %b want 0 1", ss2[1], mo2[1]);
      end
      $display("[TB] back-to-back: gap %0d, frame2 mosi %b", wc2 + 1, frame_bits(mo2));
   endtask

   task automatic test_read_data;
      int wc; logic [31:0] ss_t, mo_t, rv_t, rdy_t; logic [7:0] rd;
      logic [10:0] want; logic [7:0] want_rsp; logic [31:0] want_rv;
      run_frame(2'b01, 8'h96, 1'b0, WR_CYC, 8'h00, wc, ss_t, mo_t, rv_t, rdy_t, rd);
      want = exp_frame_q.pop_front();
      tests_run++;
      if (frame_bits(mo_t) !== want) begin
         tests_failed++;
         $display("FAIL rd_wr_frame: got %b want %b", frame_bits(mo_t), want);
      end
      run_frame(2'b11, 8'h00, 1'b0, RD_CYC, 8'h96, wc, ss_t, mo_t, rv_t, rdy_t, rd);
      want = exp_frame_q.pop_front();
      want_rsp = exp_rsp_q.pop_front();
      want_rv = '0;
      want_rv[20 + RD_WAIT] = 1'b1;
      tests_run++;
      if (frame_bits(mo_t) !== want || mo_t[RD_CYC:12] !== '0) begin
         tests_failed++;
         $display("FAIL rd_frame: got %b tail %b want %b tail 0", frame_bits(mo_t), mo_t[RD_CYC:12], want);
      end
      tests_run++;
      if (rv_t !== want_rv) begin
         tests_failed++;
         $display("FAIL rd_rsp_valid: trace %b want %b", rv_t, want_rv);
      end
      tests_run++;
      if (rd !== want_rsp) begin
         tests_failed++;
         $display("FAIL rd_rsp_data: got %h want %h", rd, want_rsp);
      end
      tests_run++;
      if (ss_t[RD_CYC:1] !== high_from(20 + RD_WAIT, RD_CYC)[RD_CYC:1]) begin
         tests_failed++;
         $display("FAIL rd_ss_n: got %b want %b", ss_t[RD_CYC:1], high_from(20 + RD_WAIT, RD_CYC)[RD_CYC:1]);
      end
      @(negedge clk);
      tests_run++;
      if (rsp_data !== want_rsp || rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rd_hold: rsp_data %h rsp_valid %b want %h 0", rsp_data, rsp_valid, want_rsp);
      end
      $display("[TB] read data: rsp %h rsp_valid trace %b", rd, rv_t[RD_CYC:1]);
   endtask

   task automatic test_end_to_end;
      logic [1:0] ops [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [7:0] data [4] = '{8'h10, 8'hC3, 8'h10, 8'h5A};
      int wc; logic [31:0] ss_t, mo_t, rv_t, rdy_t; logic [7:0] rd;
      logic [10:0] want;
      for (int k = 0; k < 4; k++) begin
         run_frame(ops[k], data[k], 1'b0, (ops[k] == 2'b11) ? RD_CYC : WR_CYC, 8'hC3,
                   wc, ss_t, mo_t, rv_t, rdy_t, rd);
         want = exp_frame_q.pop_front();
         tests_run++;
         if (frame_bits(mo_t) !== want) begin
            tests_failed++;
            $display("FAIL e2e_frame%0d: got %b want %b", k, frame_bits(mo_t), want);
         end
         if (ops[k] == 2'b11) begin
            tests_run++;
            if (rv_t === 32'd0 || rd !== exp_rsp_q.pop_front()) begin
               tests_failed++;
               $display("FAIL e2e_rsp: rsp_valid trace %b rsp_data %h want pulse with c3", rv_t, rd);
            end
         end else begin
            tests_run++;
            if (rv_t !== 32'd0) begin
               tests_failed++;
               $display("FAIL e2e_no_rsp%0d: rsp_valid trace %b want 0", k, rv_t);
            end
         end
         $display("[TB] e2e op %b data %h: mosi %b rsp %h", ops[k], data[k], frame_bits(mo_t), rd);
      end
   endtask

   task automatic test_hold_valid;
      int wc; logic [31:0] ss_t, mo_t, rv_t, rdy_t; logic [7:0] rd;
      logic [10:0] want; int extra = 0;
      run_frame(2'b01, 8'h5A, 1'b1, 12, 8'h00, wc, ss_t, mo_t, rv_t, rdy_t, rd);
      want = exp_frame_q.pop_front();
      tests_run++;
      if (frame_bits(mo_t) !== want) begin
         tests_failed++;
         $display("FAIL hold_frame: got %b want %b", frame_bits(mo_t), want);
      end
      tests_run++;
      if (rdy_t[12:1] !== 12'd0) begin
         tests_failed++;
         $display("FAIL hold_ready: cmd_ready trace %b want all 0", rdy_t[12:1]);
      end
      repeat (4) begin
         @(negedge clk);
         if (ss_n !== 1'b1) extra++;
      end
      tests_run++;
      if (extra != 0) begin
         tests_failed++;
         $display("FAIL hold_no_refire: ss_n low on %0d cycles after release, want 0", extra);
      end
      $display("[TB] hold valid: mosi %b", frame_bits(mo_t));
   endtask

   task automatic test_reset_midframe;
      int wc; int pulses = 0;
      accept_cmd(2'b00, 8'hA5, 1'b0, wc);
      repeat (4) @(negedge clk);
      tests_run++;
      if (wc < 0 || MOSI !== 1'b1 || ss_n !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_pre: accept %0d MOSI %b ss_n %b want MOSI 1 ss_n 0", wc, MOSI, ss_n);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (ss_n !== 1'b1 || MOSI !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_async: ss_n %b MOSI %b want 1 0", ss_n, MOSI);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_release: cmd_ready %b rsp_valid %b busy %b want 1 0 0",
                  cmd_ready, rsp_valid, busy);
      end
      // Abort a read-data frame in the middle of capture.
      accept_cmd(2'b11, 8'h00, 1'b0, wc);
      repeat (18) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) pulses++;
      end
      tests_run++;
      if (wc < 0 || pulses != 0) begin
         tests_failed++;
         $display("FAIL rst_no_rsp: accept %0d rsp_valid pulses %0d want 0", wc, pulses);
      end
      $display("[TB] reset mid-frame: rsp_valid pulses after abort %0d", pulses);
   endtask

   initial begin
      test_reset();
      test_write_addr();
      test_back_to_back();
      test_read_data();
      test_end_to_end();
      test_hold_valid();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
